// File: rtl/dff_pkg.sv
// Shared definitions for the stallable register pipeline: the default
// reset value of the data stages and the width of the occupancy counter.
package dff_pkg;

    localparam int unsigned DFF_DEFAULT_RESET_VAL = 0;

    // Bits needed to hold a count from 0 up to and including depth.
    function automatic int unsigned dff_count_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: a WIDTH-bit data register plus its valid bit.
// Data only loads when the incoming beat is valid, so bubbles passing
// through do not toggle the data register.
module dff_pipe_stage
    import dff_pkg::*;
#(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(DFF_DEFAULT_RESET_VAL)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             en,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o
);

    logic             vld_q;
    logic [WIDTH-1:0] dat_q;

    // Reset wins over flush; flush only drops the valid and leaves data alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= 1'b0;
            dat_q <= RESET_VAL;
        end else if (flush) begin
            vld_q <= 1'b0;
        end else if (en) begin
            vld_q <= src_valid;
            if (src_valid) begin
                dat_q <= src_data;
            end
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/dff_pipe_stall.sv
// DEPTH-stage, WIDTH-bit register pipeline with valid/ready backpressure.
// An empty stage always advances, so bubbles collapse and the pipeline
// fills to DEPTH beats before in_ready drops. The last stage drives the
// outputs directly.
module dff_pipe_stall
    import dff_pkg::*;
#(
    parameter int unsigned       WIDTH     = 8,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(DFF_DEFAULT_RESET_VAL)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic                                in_valid,
    input  logic [WIDTH-1:0]                    in_data,
    output logic                                in_ready,
    output logic                                out_valid,
    output logic [WIDTH-1:0]                    out_data,
    input  logic                                out_ready,
    output logic [dff_count_width(DEPTH)-1:0]   count
);

    localparam int unsigned CW = dff_count_width(DEPTH);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] en;
    logic [DEPTH-1:0] src_vld;
    logic [WIDTH-1:0] dat     [DEPTH];
    logic [WIDTH-1:0] src_dat [DEPTH];
    logic             chain;
    logic [CW-1:0]    cnt_sum;

    // Advance-enable chain, walked from the output side: a stage moves
    // when it is empty or the stage after it moves.
    always_comb begin
        chain = out_ready;
        en    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain = chain | ~vld[i];
            en[i] = chain;
        end
    end

    assign in_ready = en[0] & ~flush & ~reset;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign src_vld[i] = in_valid & in_ready;
            assign src_dat[i] = in_data;
        end else begin : g_body
            assign src_vld[i] = vld[i-1];
            assign src_dat[i] = dat[i-1];
        end

        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .en        (en[i]),
            .src_valid (src_vld[i]),
            .src_data  (src_dat[i]),
            .vld_o     (vld[i]),
            .dat_o     (dat[i])
        );
    end

    // Occupancy is the population count of the stage valids.
    always_comb begin
        cnt_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_sum = cnt_sum + CW'(vld[i]);
        end
    end

    assign count     = cnt_sum;
    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: tb/tb_dff_pipe_stall.sv
// Directed bench for dff_pipe_stall: a vector table for streaming and
// stall/fill, hand sequences for bubble collapse, flush, mid-stream reset
// and the single-stage configuration.
module tb_dff_pipe_stall;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, flush, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid;
    logic [7:0] out_data;
    logic [2:0] count;

    logic       d1_flush, d1_in_valid, d1_out_ready;
    logic [7:0] d1_in_data;
    logic       d1_in_ready, d1_out_valid;
    logic [7:0] d1_out_data;
    logic [0:0] d1_count;

    int tests = 0;
    int fails = 0;

    dff_pipe_stall #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count)
    );

    dff_pipe_stall #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut1 (
        .clk(clk), .reset(reset), .flush(d1_flush),
        .in_valid(d1_in_valid), .in_data(d1_in_data), .in_ready(d1_in_ready),
        .out_valid(d1_out_valid), .out_data(d1_out_data), .out_ready(d1_out_ready),
        .count(d1_count)
    );

    typedef struct packed {
        logic       rst;
        logic       fl;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       ov;
        logic [7:0] od;
        logic [2:0] cnt;
        logic       irdy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs mid-cycle, check state-derived outputs and in_ready,
    // then let the next rising edge happen.
    task automatic step(input logic r, input logic f, input logic iv, input logic [7:0] d,
                        input logic ordy, input logic eov, input logic [7:0] eod,
                        input logic [2:0] ecnt, input logic eirdy, input string name);
        @(negedge clk);
        reset = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        chk({name, ".out_valid"}, {7'd0, out_valid}, {7'd0, eov});
        chk({name, ".out_data"},  out_data, eod);
        chk({name, ".count"},     {5'd0, count}, {5'd0, ecnt});
        chk({name, ".in_ready"},  {7'd0, in_ready}, {7'd0, eirdy});
    endtask

    task automatic d1_step(input logic iv, input logic [7:0] d, input logic ordy,
                           input logic eov, input logic [7:0] eod, input logic eirdy,
                           input string name);
        @(negedge clk);
        d1_in_valid = iv; d1_in_data = d; d1_out_ready = ordy;
        #1;
        chk({name, ".out_valid"}, {7'd0, d1_out_valid}, {7'd0, eov});
        chk({name, ".out_data"},  d1_out_data, eod);
        chk({name, ".count"},     {7'd0, d1_count}, {7'd0, eov});
        chk({name, ".in_ready"},  {7'd0, d1_in_ready}, {7'd0, eirdy});
    endtask

    function automatic void add(input logic iv, input logic [7:0] d, input logic ordy,
                                input logic ov, input logic [7:0] od,
                                input logic [2:0] cnt, input logic irdy);
        vecs.push_back({1'b0, 1'b0, iv, d, ordy, ov, od, cnt, irdy});
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        d1_flush = 1'b0; d1_in_valid = 1'b0; d1_in_data = 8'h00; d1_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        step(1, 0, 0, 8'h00, 0, 0, 8'hA5, 0, 0, "reset_hold");

        // Streaming 01..08 with out_ready high: 4-edge latency, no gaps.
        add(1, 8'h01, 1, 0, 8'hA5, 0, 1);
        add(1, 8'h02, 1, 0, 8'hA5, 1, 1);
        add(1, 8'h03, 1, 0, 8'hA5, 2, 1);
        add(1, 8'h04, 1, 0, 8'hA5, 3, 1);
        add(1, 8'h05, 1, 1, 8'h01, 4, 1);
        add(1, 8'h06, 1, 1, 8'h02, 4, 1);
        add(1, 8'h07, 1, 1, 8'h03, 4, 1);
        add(1, 8'h08, 1, 1, 8'h04, 4, 1);
        add(0, 8'h00, 1, 1, 8'h05, 4, 1);
        add(0, 8'h00, 1, 1, 8'h06, 3, 1);
        add(0, 8'h00, 1, 1, 8'h07, 2, 1);
        add(0, 8'h00, 1, 1, 8'h08, 1, 1);
        add(0, 8'h00, 1, 0, 8'h08, 0, 1);
        // Stall fill to 4, then simultaneous pop/push, then drain.
        add(1, 8'h01, 0, 0, 8'h08, 0, 1);
        add(1, 8'h02, 0, 0, 8'h08, 1, 1);
        add(1, 8'h03, 0, 0, 8'h08, 2, 1);
        add(1, 8'h04, 0, 0, 8'h08, 3, 1);
        add(1, 8'h05, 0, 1, 8'h01, 4, 0);
        add(1, 8'h05, 0, 1, 8'h01, 4, 0);
        add(1, 8'h05, 1, 1, 8'h01, 4, 1);
        add(1, 8'h06, 1, 1, 8'h02, 4, 1);
        add(0, 8'h00, 1, 1, 8'h03, 4, 1);
        add(0, 8'h00, 1, 1, 8'h04, 3, 1);
        add(0, 8'h00, 1, 1, 8'h05, 2, 1);
        add(0, 8'h00, 1, 1, 8'h06, 1, 1);
        add(0, 8'h00, 1, 0, 8'h06, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy,
                 vecs[i].ov, vecs[i].od, vecs[i].cnt, vecs[i].irdy, $sformatf("vec%0d", i));
        end

        // Bubble collapse: 10, bubble, 11 while stalled.
        step(0, 0, 1, 8'h10, 0, 0, 8'h06, 0, 1, "bub0");
        step(0, 0, 0, 8'h00, 0, 0, 8'h06, 1, 1, "bub1");
        step(0, 0, 1, 8'h11, 0, 0, 8'h06, 1, 1, "bub2");
        step(0, 0, 0, 8'h00, 0, 0, 8'h06, 2, 1, "bub3");
        step(0, 0, 0, 8'h00, 0, 1, 8'h10, 2, 1, "bub4");
        step(0, 0, 0, 8'h00, 0, 1, 8'h10, 2, 1, "bub5");
        step(0, 0, 0, 8'h00, 1, 1, 8'h10, 2, 1, "bub6");
        step(0, 0, 0, 8'h00, 1, 1, 8'h11, 1, 1, "bub7");
        step(0, 0, 0, 8'h00, 1, 0, 8'h11, 0, 1, "bub8");

        // Flush with three beats held and 77 presented.
        step(0, 0, 1, 8'h31, 0, 0, 8'h11, 0, 1, "fl0");
        step(0, 0, 1, 8'h32, 0, 0, 8'h11, 1, 1, "fl1");
        step(0, 0, 1, 8'h33, 0, 0, 8'h11, 2, 1, "fl2");
        step(0, 1, 1, 8'h77, 0, 0, 8'h11, 3, 0, "fl3");
        step(0, 0, 0, 8'h00, 1, 0, 8'h11, 0, 1, "fl4");
        step(0, 0, 0, 8'h00, 1, 0, 8'h11, 0, 1, "fl5");
        step(0, 0, 0, 8'h00, 1, 0, 8'h11, 0, 1, "fl6");
        step(0, 0, 0, 8'h00, 1, 0, 8'h11, 0, 1, "fl7");

        // Reset while full and streaming.
        step(0, 0, 1, 8'h41, 1, 0, 8'h11, 0, 1, "rs0");
        step(0, 0, 1, 8'h42, 1, 0, 8'h11, 1, 1, "rs1");
        step(0, 0, 1, 8'h43, 1, 0, 8'h11, 2, 1, "rs2");
        step(0, 0, 1, 8'h44, 1, 0, 8'h11, 3, 1, "rs3");
        step(0, 0, 1, 8'h45, 1, 1, 8'h41, 4, 1, "rs4");
        step(1, 0, 1, 8'h46, 1, 1, 8'h42, 4, 0, "rs5");
        step(0, 0, 0, 8'h00, 1, 0, 8'hA5, 0, 1, "rs6");
        step(0, 0, 0, 8'h00, 1, 0, 8'hA5, 0, 1, "rs7");
        step(0, 0, 0, 8'h00, 1, 0, 8'hA5, 0, 1, "rs8");

        // Single-stage pipeline: in_ready = ~vld | out_ready.
        d1_step(1, 8'hAB, 0, 0, 8'h00, 1, "d1_0");
        d1_step(1, 8'hCD, 0, 1, 8'hAB, 0, "d1_1");
        d1_step(1, 8'hCD, 1, 1, 8'hAB, 1, "d1_2");
        d1_step(0, 8'h00, 1, 1, 8'hCD, 1, "d1_3");
        d1_step(0, 8'h00, 1, 0, 8'hCD, 1, "d1_4");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
